// File: rtl/cache_line_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_line_ctrl_pkg
// Shared definitions for the cache line miss sequencer:
//   - FSM state encoding (3 bits)
//   - line geometry (words per line, word offset width)
//   - low-order address assembly: a word address is {tag, index, word, 1'b0}
// ---------------------------------------------------------------------------
package cache_line_ctrl_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = $clog2(WORDS_PER_LINE);
  localparam int STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_WB       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_FIN      = 3'd4
  } state_t;

  // Low bits of a memory address: word offset followed by a zero byte bit.
  // Callers prepend {tag, index}.
  function automatic logic [WORD_W:0] word_lsbs(input logic [WORD_W-1:0] word);
    return {word, 1'b0};
  endfunction

endpackage

// File: rtl/cache_line_ctrl_line_word_counter.sv
// ---------------------------------------------------------------------------
// line_word_dff / line_word_counter
// line_word_dff     : single flop, async active-low reset.
// line_word_counter : word-offset counter over one cache line, built from
//                     line_word_dff cells. Wraps naturally after the last word.
// Ports (counter):
//   clk, rst (active-low async), clr (sync clear, wins over en),
//   en (advance by one), cnt (current word), last (cnt is the final word)
// ---------------------------------------------------------------------------
module line_word_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

module line_word_counter
  import cache_line_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [WORD_W-1:0] cnt,
  output logic              last
);

  logic [WORD_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clr)     cnt_next = '0;
    else if (en) cnt_next = cnt + 1'b1;
  end

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
      line_word_dff u_dff (
        .clk (clk),
        .rst (rst),
        .d   (cnt_next[gi]),
        .q   (cnt[gi])
      );
    end
  endgenerate

  assign last = &cnt;

endmodule

// File: rtl/cache_line_ctrl.sv
// ---------------------------------------------------------------------------
// cache_line_ctrl
// Miss-handling sequencer between the cache tag/data arrays and main memory.
// On an accepted miss it optionally writes back the dirty victim (4 words),
// then issues 4 pipelined reads, writes each returned word into the data
// array and finally sets tag/valid for the line.
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_dirty/req_tag_victim/req_tag_new/req_index : miss request
//   req_ack        : combinational accept pulse in the IDLE cycle
//   mem_wr/mem_rd/mem_addr : one-word memory strobe and its address
//   mem_stall      : memory refused the strobe; the same word is reissued
//   mem_rd_valid   : one read word returned, in issue order
//   cache_word/cache_wr : data-array word offset and write strobe
//   cache_valid_set: write tag, valid=1, dirty=0 at the latched index
//   busy, done     : FSM not idle / one-cycle completion pulse
// ---------------------------------------------------------------------------
module cache_line_ctrl
  import cache_line_ctrl_pkg::*;
#(
  parameter int TAG_W  = 5,
  parameter int IDX_W  = 8,
  parameter int ADDR_W = TAG_W + IDX_W + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_dirty,
  input  logic [TAG_W-1:0]  req_tag_victim,
  input  logic [TAG_W-1:0]  req_tag_new,
  input  logic [IDX_W-1:0]  req_index,
  output logic              req_ack,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_stall,
  input  logic              mem_rd_valid,
  output logic [WORD_W-1:0] cache_word,
  output logic              cache_wr,
  output logic              cache_valid_set,
  output logic              busy,
  output logic              done
);

  state_t             state_reg;
  logic [TAG_W-1:0]   tag_victim_reg;
  logic [TAG_W-1:0]   tag_new_reg;
  logic [IDX_W-1:0]   index_reg;

  logic               accept;
  logic               issue_en;
  logic               ret_en;
  logic [WORD_W-1:0]  issue_cnt;
  logic [WORD_W-1:0]  ret_cnt;
  logic               issue_last;
  logic               ret_last;

  assign accept   = (state_reg == ST_IDLE) && req_valid;
  // Only strobing states consume mem_stall; only read states accept returns.
  assign issue_en = ((state_reg == ST_WB) || (state_reg == ST_RD_ISSUE)) && !mem_stall;
  assign ret_en   = ((state_reg == ST_RD_ISSUE) || (state_reg == ST_RD_WAIT)) && mem_rd_valid;

  line_word_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .last (issue_last)
  );

  line_word_counter u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (ret_en),
    .cnt  (ret_cnt),
    .last (ret_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      tag_victim_reg <= '0;
      tag_new_reg    <= '0;
      index_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            tag_victim_reg <= req_tag_victim;
            tag_new_reg    <= req_tag_new;
            index_reg      <= req_index;
            state_reg      <= req_dirty ? ST_WB : ST_RD_ISSUE;
          end
        end
        ST_WB: begin
          if (!mem_stall && issue_last) state_reg <= ST_RD_ISSUE;
        end
        ST_RD_ISSUE: begin
          // With a zero-gap return the last word can come back in the same
          // cycle its read is accepted; skip RD_WAIT in that case.
          if (!mem_stall && issue_last)
            state_reg <= (ret_en && ret_last) ? ST_FIN : ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (ret_en && ret_last) state_reg <= ST_FIN;
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode directly from the registered state and counters, so they
  // hold steady through a stall without any extra bookkeeping.
  always_comb begin
    mem_wr          = (state_reg == ST_WB);
    mem_rd          = (state_reg == ST_RD_ISSUE);
    mem_addr        = '0;
    case (state_reg)
      ST_WB:       mem_addr = {tag_victim_reg, index_reg, word_lsbs(issue_cnt)};
      ST_RD_ISSUE: mem_addr = {tag_new_reg, index_reg, word_lsbs(issue_cnt)};
      default:     mem_addr = '0;
    endcase
    cache_word      = (state_reg == ST_WB) ? issue_cnt : ret_cnt;
    cache_wr        = ret_en;
    cache_valid_set = (state_reg == ST_FIN);
    done            = (state_reg == ST_FIN);
    busy            = (state_reg != ST_IDLE);
    // req_valid may be high while reset is held; keep the ack quiet then.
    req_ack         = rst && accept;
  end

endmodule
